// File: rtl/rsa_block_packer.sv
// ============================================================================
// Module  : rsa_block_packer
// Brief   : Sizes the RSA modulus, then packs RX bytes LSB-first into
//           (n_len-1)-bit zero-padded blocks for the FME core.
// Options : define RSA_PACKER_LAST_EN to add the fme_last output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rsa_block_packer #(
  parameter int KEY_W  = 32,
  parameter int DATA_W = 8,
  parameter int LEN_W  = $clog2(KEY_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [KEY_W-1:0]  n_key,
  input  logic              eot_in,
  input  logic              ready_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              clear_rx_flag,
  output logic              start_out,
  output logic [LEN_W-1:0]  n_len_out,
  input  logic              fme_ready,
  output logic              fme_start,
  output logic [KEY_W-1:0]  fme_data,
  output logic              done,
  output logic              size_err
`ifdef RSA_PACKER_LAST_EN
  ,
  output logic              fme_last
`endif
);

  localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SIZING   = 3'd1,
    S_PACK     = 3'd2,
    S_PADDING  = 3'd3,
    S_WAIT_FME = 3'd4
  } state_t;

  state_t            r_state;
  logic [LEN_W-1:0]  r_n_len;
  logic [KEY_W-1:0]  r_key_buf;
  logic [KEY_W-1:0]  r_pack;
  logic [LEN_W-1:0]  r_pack_count;
  logic [BC_W-1:0]   r_bit_count;
  logic [DATA_W-1:0] r_buf;
  logic              r_eot;
  logic              r_start_out;
  logic              r_fme_start;
  logic              r_done;
  logic              r_size_err;
`ifdef RSA_PACKER_LAST_EN
  logic              r_last;
`endif

  logic [LEN_W-1:0]  w_blk;
  logic              w_pack_full;
  logic              w_bc_zero;
  logic              w_take_eot;
  logic              w_take_byte;

  assign w_blk       = r_n_len - LEN_W'(1);
  assign w_pack_full = (r_pack_count == w_blk);
  assign w_bc_zero   = (r_bit_count == '0);
  assign w_take_eot  = (r_state == S_PACK) && !w_pack_full && w_bc_zero && eot_in;
  assign w_take_byte = (r_state == S_PACK) && !w_pack_full && w_bc_zero && !eot_in && ready_in;

  // Gated by rst_n so every output reads 0 while reset is held.
  assign clear_rx_flag = rst_n && ((r_state == S_IDLE) || w_take_eot || w_take_byte);

  assign start_out = r_start_out;
  assign n_len_out = r_n_len;
  assign fme_start = r_fme_start;
  assign fme_data  = r_pack;
  assign done      = r_done;
  assign size_err  = r_size_err;
`ifdef RSA_PACKER_LAST_EN
  assign fme_last  = r_last;
`endif

  function automatic logic [BC_W-1:0] next_bc(input logic [BC_W-1:0] c);
    return (c == BC_W'(DATA_W - 1)) ? '0 : c + BC_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_n_len      <= '0;
      r_key_buf    <= '0;
      r_pack       <= '0;
      r_pack_count <= '0;
      r_bit_count  <= '0;
      r_buf        <= '0;
      r_eot        <= 1'b0;
      r_start_out  <= 1'b0;
      r_fme_start  <= 1'b0;
      r_done       <= 1'b0;
      r_size_err   <= 1'b0;
`ifdef RSA_PACKER_LAST_EN
      r_last       <= 1'b0;
`endif
    end else begin
      r_start_out <= 1'b0;
      r_fme_start <= 1'b0;
      r_done      <= 1'b0;
      r_size_err  <= 1'b0;
`ifdef RSA_PACKER_LAST_EN
      r_last      <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          r_n_len   <= '0;
          r_key_buf <= n_key;
          if (start) r_state <= S_SIZING;
        end

        S_SIZING: begin
          if (r_key_buf != '0) begin
            r_n_len   <= r_n_len + LEN_W'(1);
            r_key_buf <= r_key_buf >> 1;
          end else if (r_n_len < LEN_W'(2)) begin
            r_size_err <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_start_out  <= 1'b1;
            r_pack       <= '0;
            r_pack_count <= '0;
            r_bit_count  <= '0;
            r_buf        <= '0;
            r_eot        <= 1'b0;
            r_state      <= S_PACK;
          end
        end

        S_PACK: begin
          if (w_pack_full) begin
            r_state <= S_PADDING;
          end else if (w_bc_zero) begin
            if (eot_in) begin
              // An empty trailing block is never sent to the FME core.
              if (r_pack_count == '0) begin
                r_done  <= 1'b1;
                r_eot   <= 1'b0;
                r_state <= S_IDLE;
              end else begin
                r_eot   <= 1'b1;
                r_state <= S_PADDING;
              end
            end else if (ready_in) begin
              r_pack       <= {data_in[0], r_pack[KEY_W-1:1]};
              r_buf        <= data_in >> 1;
              r_pack_count <= r_pack_count + LEN_W'(1);
              r_bit_count  <= next_bc('0);
            end
          end else begin
            r_pack       <= {r_buf[0], r_pack[KEY_W-1:1]};
            r_buf        <= r_buf >> 1;
            r_pack_count <= r_pack_count + LEN_W'(1);
            r_bit_count  <= next_bc(r_bit_count);
          end
        end

        S_PADDING: begin
          if (r_pack_count == LEN_W'(KEY_W)) begin
            r_state <= S_WAIT_FME;
          end else begin
            r_pack       <= r_pack >> 1;
            r_pack_count <= r_pack_count + LEN_W'(1);
          end
        end

        S_WAIT_FME: begin
          if (fme_ready) begin
            r_fme_start  <= 1'b1;
`ifdef RSA_PACKER_LAST_EN
            r_last       <= r_eot;
`endif
            r_pack_count <= '0;
            if (r_eot) begin
              r_done  <= 1'b1;
              r_eot   <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_PACK;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rsa_block_packer.sv
// ============================================================================
// Module  : tb_rsa_block_packer
// Brief   : Directed self-checking bench for rsa_block_packer (KEY_W=32, DATA_W=8).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rsa_block_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] n_key;
  logic        eot_in;
  logic        ready_in;
  logic [7:0]  data_in;
  logic        clear_rx_flag;
  logic        start_out;
  logic [5:0]  n_len_out;
  logic        fme_ready;
  logic        fme_start;
  logic [31:0] fme_data;
  logic        done;
  logic        size_err;
`ifdef RSA_PACKER_LAST_EN
  logic        fme_last;
`endif

  int vectors     = 0;
  int miscompares = 0;

  int          n_so   = 0;
  int          n_se   = 0;
  int          n_done = 0;
  int          nb     = 0;
  logic [31:0] blk [0:63];
  logic        lst [0:63];

  always #5 clk = ~clk;

  rsa_block_packer #(.KEY_W(32), .DATA_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .n_key         (n_key),
    .eot_in        (eot_in),
    .ready_in      (ready_in),
    .data_in       (data_in),
    .clear_rx_flag (clear_rx_flag),
    .start_out     (start_out),
    .n_len_out     (n_len_out),
    .fme_ready     (fme_ready),
    .fme_start     (fme_start),
    .fme_data      (fme_data),
    .done          (done),
    .size_err      (size_err)
`ifdef RSA_PACKER_LAST_EN
    ,
    .fme_last      (fme_last)
`endif
  );

  // Pulse monitor; the stimulus reads these counters 1 time unit after negedge.
  always @(negedge clk) begin
    if (start_out) n_so = n_so + 1;
    if (size_err)  n_se = n_se + 1;
    if (done)      n_done = n_done + 1;
    if (fme_start && nb < 64) begin
      blk[nb] = fme_data;
`ifdef RSA_PACKER_LAST_EN
      lst[nb] = fme_last;
`else
      lst[nb] = 1'b0;
`endif
      nb = nb + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic begin_session(input logic [31:0] key, output int cyc);
    tick();
    n_key = key;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!start_out && cyc < 50) begin
      tick();
      cyc++;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    tick();
    data_in  = b;
    ready_in = 1'b1;
    #1;
    while (!clear_rx_flag && n < 1000) begin
      tick();
      n++;
    end
    check("rx_byte_taken", {31'b0, n < 1000}, 32'd1);
    tick();
    ready_in = 1'b0;
  endtask

  task automatic send_eot();
    int n = 0;
    tick();
    eot_in = 1'b1;
    #1;
    while (!clear_rx_flag && n < 1000) begin
      tick();
      n++;
    end
    check("eot_taken", {31'b0, n < 1000}, 32'd1);
    tick();
    eot_in = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (n_done == d0 && n < 1000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int          cyc;
    int          nb0;
    int          so0;
    int          se0;
    int          d0;
    logic [7:0]  bval;

    rst_n = 1'b0; start = 1'b0; n_key = '0; eot_in = 1'b0;
    ready_in = 1'b0; data_in = '0; fme_ready = 1'b1;

    // Reset state
    #3;
    check("rst_clear_rx", {31'b0, clear_rx_flag}, 32'd0);
    check("rst_start_out", {31'b0, start_out}, 32'd0);
    check("rst_fme_start", {31'b0, fme_start}, 32'd0);
    check("rst_n_len", {26'b0, n_len_out}, 32'd0);
    check("rst_fme_data", fme_data, 32'd0);
    check("rst_done_err", {30'b0, done, size_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle_clear_rx", {31'b0, clear_rx_flag}, 32'd1);

    // Session 1: key 0xFF, byte 0xA5, EOT
    so0 = n_so; nb0 = nb; d0 = n_done;
    begin_session(32'hFF, cyc);
    check("s1_size_cycles", cyc, 32'd9);
    check("s1_n_len", {26'b0, n_len_out}, 32'd8);
    tick();
    check("s1_start_pulse_end", {31'b0, start_out}, 32'd0);
    check("s1_start_count", n_so - so0, 32'd1);
    send_byte(8'hA5);
    send_eot();
    wait_done(d0);
    check("s1_done_count", n_done - d0, 32'd1);
    check("s1_block_count", nb - nb0, 32'd2);
    check("s1_block0", blk[nb0], 32'h25);
    check("s1_block1", blk[nb0+1], 32'h01);
`ifdef RSA_PACKER_LAST_EN
    check("s1_last0", {31'b0, lst[nb0]}, 32'd0);
    check("s1_last1", {31'b0, lst[nb0+1]}, 32'd1);
`endif
    tick();
    check("s1_back_idle", {31'b0, clear_rx_flag}, 32'd1);

    // Session 2: key 0x1 is too short
    so0 = n_so; se0 = n_se;
    tick();
    n_key = 32'h1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("s2_size_err", n_se - se0, 32'd1);
    check("s2_no_start_out", n_so - so0, 32'd0);
    check("s2_idle", {31'b0, clear_rx_flag}, 32'd1);

    // Session 3: key 0x2 gives 1-bit blocks; EOT lands on a block boundary
    nb0 = nb; d0 = n_done;
    bval = 8'h01;
    begin_session(32'h2, cyc);
    check("s3_size_cycles", cyc, 32'd3);
    check("s3_n_len", {26'b0, n_len_out}, 32'd2);
    send_byte(bval);
    send_eot();
    wait_done(d0);
    check("s3_done_count", n_done - d0, 32'd1);
    check("s3_block_count", nb - nb0, 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("s3_block%0d", i), blk[nb0+i], {31'b0, bval[i]});
`ifdef RSA_PACKER_LAST_EN
      check($sformatf("s3_last%0d", i), {31'b0, lst[nb0+i]}, 32'd0);
`endif
    end

    // Session 4: FME stalls after padding
    nb0 = nb; d0 = n_done;
    fme_ready = 1'b0;
    begin_session(32'hFF, cyc);
    send_byte(8'h3C);
    repeat (60) tick();
    check("s4_no_start_early", nb - nb0, 32'd0);
    check("s4_data_held", fme_data, 32'h3C);
    repeat (20) tick();
    check("s4_still_waiting", nb - nb0, 32'd0);
    check("s4_data_stable", fme_data, 32'h3C);
    fme_ready = 1'b1;
    cyc = 0;
    while (nb == nb0 && cyc < 10) begin
      tick();
      cyc++;
    end
    check("s4_start_after_ready", nb - nb0, 32'd1);
    check("s4_block0", blk[nb0], 32'h3C);
    send_eot();
    wait_done(d0);
    check("s4_done_count", n_done - d0, 32'd1);
    check("s4_block1", blk[nb0+1], 32'h00);
`ifdef RSA_PACKER_LAST_EN
    check("s4_last1", {31'b0, lst[nb0+1]}, 32'd1);
`endif

    // Session 5: reset in the middle of PACK, then resize
    nb0 = nb;
    begin_session(32'hFF, cyc);
    send_byte(8'hFF);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("s5_rst_clear_rx", {31'b0, clear_rx_flag}, 32'd0);
    check("s5_rst_n_len", {26'b0, n_len_out}, 32'd0);
    check("s5_rst_fme_data", fme_data, 32'd0);
    check("s5_rst_pulses", {28'b0, start_out, fme_start, done, size_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) tick();
    check("s5_no_block", nb - nb0, 32'd0);
    begin_session(32'hF, cyc);
    check("s5_resize_cycles", cyc, 32'd5);
    check("s5_resize_n_len", {26'b0, n_len_out}, 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
